// File: rtl/aidc_lite_comp_buffer_pkg.sv
// Shared constants and the bank state encoding for the compressor-side
// block buffer.
package aidc_lite_pkg;

    localparam int AIDC_LITE_BLK_BYTES = 128;
    localparam int AIDC_LITE_DATA_W    = 32;
    localparam int AIDC_LITE_NUM_BANKS = 2;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL
    } bank_state_t;

    // Number of beats that make up one block.
    function automatic int words_per_block(input int blk_bytes, input int data_w);
        return (blk_bytes * 8) / data_w;
    endfunction

endpackage

// File: rtl/aidc_lite_comp_buffer_if.sv
// Engine-side write stream, compressor-side read stream and status of the
// block buffer, bundled so both ends see one port.
interface aidc_lite_comp_buffer_if
    import aidc_lite_pkg::*;
#(
    parameter int DATA_W    = AIDC_LITE_DATA_W,
    parameter int NUM_BANKS = AIDC_LITE_NUM_BANKS
);

    localparam int CNT_W = $clog2(NUM_BANKS) + 1;

    logic              flush_i;
    logic              wr_valid_i;
    logic [DATA_W-1:0] wr_data_i;
    logic              wr_ready_o;
    logic              rd_valid_o;
    logic [DATA_W-1:0] rd_data_o;
    logic              rd_last_o;
    logic              rd_ready_i;
    logic [CNT_W-1:0]  full_cnt_o;
    logic              empty_o;

    modport master (
        output flush_i,
        output wr_valid_i,
        output wr_data_i,
        output rd_ready_i,
        input  wr_ready_o,
        input  rd_valid_o,
        input  rd_data_o,
        input  rd_last_o,
        input  full_cnt_o,
        input  empty_o
    );

    modport slave (
        input  flush_i,
        input  wr_valid_i,
        input  wr_data_i,
        input  rd_ready_i,
        output wr_ready_o,
        output rd_valid_o,
        output rd_data_o,
        output rd_last_o,
        output full_cnt_o,
        output empty_o
    );

endinterface

// File: rtl/aidc_lite_comp_buffer_bank.sv
// One block of storage: a WPB-deep flop array with a clocked write port and
// a zero-latency read port. Contents are deliberately not reset.
module aidc_lite_comp_buffer_bank #(
    parameter int DATA_W = 32,
    parameter int WPB    = 32,
    localparam int AW    = $clog2(WPB)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [WPB];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/aidc_lite_comp_buffer.sv
// Ping-pong block buffer: collects engine beats into whole blocks and only
// presents a block to the compressor once every word of it has arrived.
module aidc_lite_comp_buffer
    import aidc_lite_pkg::*;
#(
    parameter int DATA_W    = AIDC_LITE_DATA_W,
    parameter int BLK_BYTES = AIDC_LITE_BLK_BYTES,
    parameter int NUM_BANKS = AIDC_LITE_NUM_BANKS
) (
    input logic                    clk,
    input logic                    rst,
    aidc_lite_comp_buffer_if.slave bus
);

    localparam int WPB    = words_per_block(BLK_BYTES, DATA_W);
    localparam int PTR_W  = $clog2(WPB);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int CNT_W  = $clog2(NUM_BANKS) + 1;

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(WPB - 1);

    bank_state_t       bank_state     [NUM_BANKS];
    bank_state_t       bank_state_nxt [NUM_BANKS];
    logic [BANK_W-1:0] wr_bank, wr_bank_nxt;
    logic [BANK_W-1:0] rd_bank, rd_bank_nxt;
    logic [PTR_W-1:0]  wr_ptr, wr_ptr_nxt;
    logic [PTR_W-1:0]  rd_ptr, rd_ptr_nxt;
    logic [CNT_W-1:0]  full_cnt, full_cnt_nxt;

    logic              wr_ready;
    logic              rd_valid;
    logic              wr_fire;
    logic              rd_fire;
    logic              wr_done;
    logic              rd_done;
    logic              any_active;
    logic [DATA_W-1:0] bank_rd_data [NUM_BANKS];

    // Handshake qualification; a flush cancels whatever would have moved.
    always_comb begin
        wr_ready = (bank_state[wr_bank] != BANK_FULL);
        rd_valid = (bank_state[rd_bank] == BANK_FULL);
        wr_fire  = bus.wr_valid_i & wr_ready & ~bus.flush_i;
        rd_fire  = rd_valid & bus.rd_ready_i & ~bus.flush_i;
        wr_done  = wr_fire & (wr_ptr == LAST_PTR);
        rd_done  = rd_fire & (rd_ptr == LAST_PTR);
    end

    // Next-state logic. While both sides point at one bank it is either
    // FILLING or FULL, so the write and read updates never hit the same bank.
    always_comb begin
        bank_state_nxt = bank_state;
        wr_bank_nxt    = wr_bank;
        rd_bank_nxt    = rd_bank;
        wr_ptr_nxt     = wr_ptr;
        rd_ptr_nxt     = rd_ptr;
        full_cnt_nxt   = full_cnt;

        if (bus.flush_i) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank_state_nxt[i] = BANK_EMPTY;
            end
            wr_bank_nxt  = '0;
            rd_bank_nxt  = '0;
            wr_ptr_nxt   = '0;
            rd_ptr_nxt   = '0;
            full_cnt_nxt = '0;
        end else begin
            if (wr_fire) begin
                if (wr_done) begin
                    bank_state_nxt[wr_bank] = BANK_FULL;
                    wr_ptr_nxt              = '0;
                    wr_bank_nxt             = wr_bank + BANK_W'(1);
                end else begin
                    bank_state_nxt[wr_bank] = BANK_FILLING;
                    wr_ptr_nxt              = wr_ptr + PTR_W'(1);
                end
            end

            if (rd_fire) begin
                if (rd_done) begin
                    bank_state_nxt[rd_bank] = BANK_EMPTY;
                    rd_ptr_nxt              = '0;
                    rd_bank_nxt             = rd_bank + BANK_W'(1);
                end else begin
                    rd_ptr_nxt              = rd_ptr + PTR_W'(1);
                end
            end

            case ({wr_done, rd_done})
                2'b10:   full_cnt_nxt = full_cnt + CNT_W'(1);
                2'b01:   full_cnt_nxt = full_cnt - CNT_W'(1);
                default: full_cnt_nxt = full_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank_state[i] <= BANK_EMPTY;
            end
            wr_bank  <= '0;
            rd_bank  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            full_cnt <= '0;
        end else begin
            bank_state <= bank_state_nxt;
            wr_bank    <= wr_bank_nxt;
            rd_bank    <= rd_bank_nxt;
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            full_cnt   <= full_cnt_nxt;
        end
    end

    // The buffer counts as empty only with no bank in use and no beat pending.
    always_comb begin
        any_active = 1'b0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (bank_state[i] != BANK_EMPTY) begin
                any_active = 1'b1;
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        aidc_lite_comp_buffer_bank #(
            .DATA_W (DATA_W),
            .WPB    (WPB)
        ) u_bank (
            .clk     (clk),
            .wr_en   (wr_fire && (wr_bank == BANK_W'(b))),
            .wr_addr (wr_ptr),
            .wr_data (bus.wr_data_i),
            .rd_addr (rd_ptr),
            .rd_data (bank_rd_data[b])
        );
    end

    assign bus.wr_ready_o = wr_ready;
    assign bus.rd_valid_o = rd_valid;
    assign bus.rd_data_o  = bank_rd_data[rd_bank];
    assign bus.rd_last_o  = rd_valid & (rd_ptr == LAST_PTR);
    assign bus.full_cnt_o = full_cnt;
    assign bus.empty_o    = ~any_active & (wr_ptr == '0);

endmodule

// File: tb/tb_aidc_lite_comp_buffer.sv
// Scoreboard bench for the block buffer: directed scenarios plus randomized
// valid/ready throttling, checked against a block-level queue model.
module tb_aidc_lite_comp_buffer;
    import aidc_lite_pkg::*;

    localparam int DATA_W    = 32;
    localparam int NUM_BANKS = 2;
    localparam int WPB       = 32;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    aidc_lite_comp_buffer_if #(.DATA_W(DATA_W), .NUM_BANKS(NUM_BANKS)) bus ();

    aidc_lite_comp_buffer #(
        .DATA_W    (DATA_W),
        .BLK_BYTES (128),
        .NUM_BANKS (NUM_BANKS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors    = 0;
    int checks    = 0;
    int readCount = 0;

    exp_t              expQ  [$];
    logic [DATA_W-1:0] pendQ [$];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle worth of inputs, then returns just after the edge.
    task automatic applyStimulus(input logic wv, input logic [DATA_W-1:0] wd,
                                 input logic rr, input logic fl);
        bus.wr_valid_i = wv;
        bus.wr_data_i  = wd;
        bus.rd_ready_i = rr;
        bus.flush_i    = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic drainAll(input string name);
        for (int k = 0; k < 200 && !(bus.empty_o && !bus.rd_valid_o); k++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
        end
        checkOutput({name, "_empty"}, bus.empty_o, 1);
        checkOutput({name, "_full_cnt"}, bus.full_cnt_o, 0);
        checkOutput({name, "_sb_drained"}, expQ.size(), 0);
    endtask

    // Reference model and monitor: accepted beats are grouped into blocks;
    // only whole blocks become readable, in order, last flag on word WPB-1.
    logic prevValid = 1'b0;
    logic prevFire  = 1'b0;
    exp_t popped;
    exp_t pushed;

    always @(negedge clk) begin
        if (rst || bus.flush_i) begin
            expQ.delete();
            pendQ.delete();
            prevValid = 1'b0;
            prevFire  = 1'b0;
        end else begin
            if (prevValid && !prevFire) begin
                checkOutput("rd_valid_hold", bus.rd_valid_o, 1);
            end
            if (!bus.rd_valid_o) begin
                checkOutput("rd_last_idle", bus.rd_last_o, 0);
            end
            if (bus.rd_valid_o && bus.rd_ready_i) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_read: got word 0x%0h, expected no valid data", bus.rd_data_o);
                end else begin
                    popped = expQ.pop_front();
                    checkOutput("rd_data", bus.rd_data_o, popped.data);
                    checkOutput("rd_last", bus.rd_last_o, popped.last);
                    readCount++;
                end
            end
            if (bus.wr_valid_i && bus.wr_ready_o) begin
                pendQ.push_back(bus.wr_data_i);
                if (pendQ.size() == WPB) begin
                    for (int i = 0; i < WPB; i++) begin
                        pushed.data = pendQ[i];
                        pushed.last = (i == WPB - 1);
                        expQ.push_back(pushed);
                    end
                    pendQ.delete();
                end
            end
            prevValid = bus.rd_valid_o;
            prevFire  = bus.rd_valid_o && bus.rd_ready_i;
        end
    end

    initial begin
        #500000;
        errors++;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0] wordVal;
        logic [DATA_W-1:0] blockStart;
        logic [DATA_W-1:0] dCur;
        logic              wvCur;
        logic              acc;
        logic              stillLow;
        int                accepted;
        int                written;
        int                readsStart;

        bus.wr_valid_i = 1'b0;
        bus.wr_data_i  = '0;
        bus.rd_ready_i = 1'b0;
        bus.flush_i    = 1'b0;
        rst            = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_wr_ready", bus.wr_ready_o, 1);
        checkOutput("rst_rd_valid", bus.rd_valid_o, 0);
        checkOutput("rst_rd_last", bus.rd_last_o, 0);
        checkOutput("rst_full_cnt", bus.full_cnt_o, 0);
        checkOutput("rst_empty", bus.empty_o, 1);

        $display("[TB] single block");
        for (int i = 0; i < WPB; i++) begin
            if (i == WPB - 1) checkOutput("t1_valid_before_last", bus.rd_valid_o, 0);
            applyStimulus(1'b1, DATA_W'(i), 1'b1, 1'b0);
        end
        checkOutput("t1_valid_after_last", bus.rd_valid_o, 1);
        checkOutput("t1_first_word", bus.rd_data_o, 0);
        checkOutput("t1_full_cnt", bus.full_cnt_o, 1);
        drainAll("t1");

        $display("[TB] back-pressure");
        wordVal  = 32'h0000_0100;
        accepted = 0;
        for (int k = 0; k < 100; k++) begin
            if (!bus.wr_ready_o) break;
            applyStimulus(1'b1, wordVal, 1'b0, 1'b0);
            wordVal++;
            accepted++;
        end
        checkOutput("t2_accepted", accepted, 2 * WPB);
        checkOutput("t2_wr_ready_low", bus.wr_ready_o, 0);
        checkOutput("t2_full_cnt", bus.full_cnt_o, 2);
        stillLow = 1'b1;
        for (int k = 0; k < WPB; k++) begin
            if (bus.wr_ready_o) stillLow = 1'b0;
            applyStimulus(1'b1, wordVal, 1'b1, 1'b0);
        end
        checkOutput("t2_wr_ready_low_during_read", stillLow, 1);
        checkOutput("t2_wr_ready_reassert", bus.wr_ready_o, 1);
        checkOutput("t2_full_cnt_after", bus.full_cnt_o, 1);
        drainAll("t2");

        $display("[TB] simultaneous completion");
        for (int k = 0; k < WPB; k++) begin
            applyStimulus(1'b1, wordVal, 1'b0, 1'b0);
            wordVal++;
        end
        blockStart = wordVal;
        for (int k = 0; k < WPB; k++) begin
            if (k == WPB - 1) checkOutput("t3_full_cnt_before", bus.full_cnt_o, 1);
            applyStimulus(1'b1, wordVal, 1'b1, 1'b0);
            wordVal++;
        end
        checkOutput("t3_full_cnt_after", bus.full_cnt_o, 1);
        checkOutput("t3_no_gap_valid", bus.rd_valid_o, 1);
        checkOutput("t3_next_block_word0", bus.rd_data_o, blockStart);
        drainAll("t3");

        $display("[TB] flush mid-block");
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, wordVal, 1'b1, 1'b0);
            wordVal++;
        end
        checkOutput("t4_not_empty", bus.empty_o, 0);
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
        checkOutput("t4_full_cnt", bus.full_cnt_o, 0);
        checkOutput("t4_empty", bus.empty_o, 1);
        checkOutput("t4_wr_ready", bus.wr_ready_o, 1);
        blockStart = wordVal;
        for (int k = 0; k < WPB; k++) begin
            applyStimulus(1'b1, wordVal, 1'b0, 1'b0);
            wordVal++;
        end
        checkOutput("t4_block_valid", bus.rd_valid_o, 1);
        checkOutput("t4_block_word0", bus.rd_data_o, blockStart);
        drainAll("t4");

        $display("[TB] async reset");
        for (int k = 0; k < WPB; k++) begin
            applyStimulus(1'b1, wordVal, 1'b0, 1'b0);
            wordVal++;
        end
        bus.wr_valid_i = 1'b0;
        checkOutput("t5_valid_before", bus.rd_valid_o, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t5_rd_valid_async", bus.rd_valid_o, 0);
        checkOutput("t5_wr_ready_async", bus.wr_ready_o, 1);
        checkOutput("t5_full_cnt_async", bus.full_cnt_o, 0);
        checkOutput("t5_empty_async", bus.empty_o, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("t5_rd_valid_after", bus.rd_valid_o, 0);

        $display("[TB] random throttling");
        readsStart = readCount;
        written    = 0;
        wvCur      = 1'b0;
        dCur       = '0;
        for (int c = 0; c < 20000 && written < 1024; c++) begin
            if (!wvCur && $urandom_range(3) != 0) begin
                wvCur = 1'b1;
                dCur  = $urandom;
            end
            acc = wvCur && bus.wr_ready_o;
            applyStimulus(wvCur, dCur, $urandom_range(2) != 0, 1'b0);
            if (acc) begin
                written++;
                wvCur = 1'b0;
            end
        end
        checkOutput("t6_all_written", written, 1024);
        drainAll("t6");
        checkOutput("t6_read_count", readCount - readsStart, 1024);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
